// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard.
//  hs_state_t       : back-end memory FSM state (RUN / D-cache miss freeze)
//  hs_entry_t       : one in-flight queue slot {valid, rd, we, rdy_stage}
//  FWD_FROM_REGFILE : forwarding select meaning "no bypass, read the register file"
// Entry fields are sized for the widest supported configuration. The top
// zero-extends its narrower inputs into them and checks the limits at
// elaboration time.
package hazard_scoreboard_pkg;

  localparam int HS_RD_MAX_W      = 8;
  localparam int HS_STG_MAX_W     = 4;
  localparam int FWD_FROM_REGFILE = 0;

  typedef enum logic [0:0] {
    HS_RUN   = 1'b0,
    HS_DMISS = 1'b1
  } hs_state_t;

  typedef struct packed {
    logic                    valid;
    logic [HS_RD_MAX_W-1:0]  rd;
    logic                    we;
    logic [HS_STG_MAX_W-1:0] rdy_stage;
  } hs_entry_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hs_match: youngest-producer search and bypass select for one source operand.
//  queue  in  in-flight entries, index k-1 = stage k (1 = EX)
//  src    in  source register address
//  used   in  operand is actually read
//  fwd    out bypass stage, FWD_FROM_REGFILE when no producer is in flight
//  hazard out youngest producer has not yet reached its ready stage
module hs_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = 5,
  parameter int STG_W      = 2
) (
  input  hs_entry_t              queue [NUM_STAGES],
  input  logic [REG_ADDR_W-1:0]  src,
  input  logic                   used,
  output logic [STG_W-1:0]       fwd,
  output logic                   hazard
);

  // Walk from the oldest stage toward EX so the youngest match is the one
  // left standing. x0 is hard-wired zero and never forwarded or stalled on.
  always_comb begin
    fwd    = STG_W'(FWD_FROM_REGFILE);
    hazard = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (queue[k-1].valid && queue[k-1].we && used && (src != '0) &&
          (queue[k-1].rd == HS_RD_MAX_W'(src))) begin
        if (HS_STG_MAX_W'(k) >= queue[k-1].rdy_stage) begin
          fwd    = STG_W'(k);
          hazard = 1'b0;
        end else begin
          fwd    = STG_W'(FWD_FROM_REGFILE);
          hazard = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline control beside decode. Tracks in-flight
// register writes, raises RAW stalls, selects EX bypass sources, flushes on
// redirect, freezes on D-cache misses and bubbles ID on I-cache misses.
// Ports:
//  clk_i, reset_ni             clock, asynchronous active-low reset
//  id_*                        instruction currently in ID
//  dmem_req_i, dcache_ready_i  MEM access and D-cache completion
//  icache_ready_i              fetch delivered this cycle
//  redirect_i                  taken branch/jump resolved in REDIRECT_STAGE
//  pc_stall_o, id_stall_o, id_flush_o, issue_o, freeze_o   pipeline control
//  fwd_rs1_o, fwd_rs2_o        bypass source stage, 0 = register file
//  stage_valid_o               queue valid bits, bit k-1 = stage k
//  raw_stall_cnt_o, miss_stall_cnt_o  saturating stall counters
//  dbg_state_o                 memory FSM state
// ID -> EX handshake: id_valid_i is the offer, issue_o is the acceptance.
// The instruction moves into EX on a clock edge only when both are high;
// while issue_o is low the ID stage must keep id_* stable (id_stall_o) or
// drop the instruction (id_flush_o).
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int REG_ADDR_W     = 5,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 32,
  localparam int STG_W         = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic                  id_rs1_used_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_rs2_used_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic                  id_we_i,
  input  logic [STG_W-1:0]      id_rdy_stage_i,
  input  logic                  dmem_req_i,
  input  logic                  dcache_ready_i,
  input  logic                  icache_ready_i,
  input  logic                  redirect_i,
  output logic                  pc_stall_o,
  output logic                  id_stall_o,
  output logic                  id_flush_o,
  output logic                  issue_o,
  output logic                  freeze_o,
  output logic [STG_W-1:0]      fwd_rs1_o,
  output logic [STG_W-1:0]      fwd_rs2_o,
  output logic [NUM_STAGES-1:0] stage_valid_o,
  output logic [CNT_W-1:0]      raw_stall_cnt_o,
  output logic [CNT_W-1:0]      miss_stall_cnt_o,
  output hs_state_t             dbg_state_o
);

  if (REG_ADDR_W > HS_RD_MAX_W || STG_W > HS_STG_MAX_W ||
      REDIRECT_STAGE < 1 || REDIRECT_STAGE > NUM_STAGES) begin : g_bad_params
    $error("hazard_scoreboard: unsupported parameter combination");
  end

  hs_state_t state;
  hs_entry_t queue [NUM_STAGES];
  logic      haz_rs1, haz_rs2;
  logic      raw_stall, frozen, redirect_take, imiss;

  hs_match #(.NUM_STAGES(NUM_STAGES), .REG_ADDR_W(REG_ADDR_W), .STG_W(STG_W)) u_match_rs1 (
    .queue(queue), .src(id_rs1_i), .used(id_rs1_used_i), .fwd(fwd_rs1_o), .hazard(haz_rs1)
  );

  hs_match #(.NUM_STAGES(NUM_STAGES), .REG_ADDR_W(REG_ADDR_W), .STG_W(STG_W)) u_match_rs2 (
    .queue(queue), .src(id_rs2_i), .used(id_rs2_used_i), .fwd(fwd_rs2_o), .hazard(haz_rs2)
  );

  // The freeze starts in the same cycle the miss is seen and lifts in the
  // cycle the D-cache completes, so it needs the live inputs beside the state.
  assign raw_stall     = id_valid_i && (haz_rs1 || haz_rs2);
  assign frozen        = ((state == HS_DMISS) || (dmem_req_i && !dcache_ready_i)) &&
                         !((state == HS_DMISS) && dcache_ready_i);
  assign redirect_take = redirect_i && !frozen;
  assign imiss         = !icache_ready_i;
  assign dbg_state_o   = state;

  // Priority: freeze > redirect > RAW stall > I-miss. While reset is held the
  // controls sit at their reset values regardless of the other inputs.
  always_comb begin
    freeze_o   = 1'b0;
    issue_o    = 1'b0;
    pc_stall_o = 1'b0;
    id_stall_o = 1'b0;
    id_flush_o = 1'b1;
    if (reset_ni) begin
      freeze_o = frozen;
      if (frozen) begin
        pc_stall_o = 1'b1;
        id_stall_o = 1'b1;
        id_flush_o = 1'b0;
      end else if (redirect_take) begin
        id_flush_o = 1'b1;
      end else begin
        issue_o    = id_valid_i && !raw_stall;
        pc_stall_o = raw_stall || imiss;
        id_stall_o = raw_stall || imiss;
        id_flush_o = imiss && !raw_stall;
      end
    end
  end

  always_comb begin
    stage_valid_o = '0;
    for (int k = 0; k < NUM_STAGES; k++) stage_valid_o[k] = queue[k].valid;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= HS_RUN;
    end else begin
      case (state)
        HS_RUN:   if (dmem_req_i && !dcache_ready_i) state <= HS_DMISS;
        HS_DMISS: if (dcache_ready_i) state <= HS_RUN;
        default:  state <= HS_RUN;
      endcase
    end
  end

  // Younger-than-redirect stages are wrong-path; they are killed on their
  // way to the next stage so the shift and the squash happen in one edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int k = 0; k < NUM_STAGES; k++) queue[k] <= '0;
    end else if (!frozen) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        queue[k] <= queue[k-1];
        if (redirect_take && (k <= REDIRECT_STAGE - 1)) queue[k].valid <= 1'b0;
      end
      if (issue_o) begin
        queue[0] <= '{valid: 1'b1, rd: HS_RD_MAX_W'(id_rd_i), we: id_we_i,
                      rdy_stage: HS_STG_MAX_W'(id_rdy_stage_i)};
      end else begin
        queue[0] <= '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      raw_stall_cnt_o  <= '0;
      miss_stall_cnt_o <= '0;
    end else begin
      if (raw_stall && !frozen && !redirect_take && (raw_stall_cnt_o != '1))
        raw_stall_cnt_o <= raw_stall_cnt_o + 1'b1;
      if ((frozen || imiss) && (miss_stall_cnt_o != '1))
        miss_stall_cnt_o <= miss_stall_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: producer/consumer bypass, load-use
// stall, youngest-match, redirect, D-miss freeze, I-miss bubbles, counter
// saturation (4-bit counters) and asynchronous reset during a miss.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NS = 3;
  localparam int RW = 5;
  localparam int SW = 2;
  localparam int CW = 4;

  // clock / reset
  logic clk_i = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          id_valid_i = 1'b0;
  logic [RW-1:0] id_rs1_i = '0;
  logic          id_rs1_used_i = 1'b0;
  logic [RW-1:0] id_rs2_i = '0;
  logic          id_rs2_used_i = 1'b0;
  logic [RW-1:0] id_rd_i = '0;
  logic          id_we_i = 1'b0;
  logic [SW-1:0] id_rdy_stage_i = '0;
  logic          dmem_req_i = 1'b0;
  logic          dcache_ready_i = 1'b1;
  logic          icache_ready_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic          pc_stall_o, id_stall_o, id_flush_o, issue_o, freeze_o;
  logic [SW-1:0] fwd_rs1_o, fwd_rs2_o;
  logic [NS-1:0] stage_valid_o;
  logic [CW-1:0] raw_stall_cnt_o, miss_stall_cnt_o;
  hs_state_t     dbg_state_o;

  hazard_scoreboard #(.NUM_STAGES(NS), .REG_ADDR_W(RW), .REDIRECT_STAGE(2), .CNT_W(CW)) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs1_used_i(id_rs1_used_i),
    .id_rs2_i(id_rs2_i), .id_rs2_used_i(id_rs2_used_i), .id_rd_i(id_rd_i),
    .id_we_i(id_we_i), .id_rdy_stage_i(id_rdy_stage_i),
    .dmem_req_i(dmem_req_i), .dcache_ready_i(dcache_ready_i),
    .icache_ready_i(icache_ready_i), .redirect_i(redirect_i),
    .pc_stall_o(pc_stall_o), .id_stall_o(id_stall_o), .id_flush_o(id_flush_o),
    .issue_o(issue_o), .freeze_o(freeze_o),
    .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o), .stage_valid_o(stage_valid_o),
    .raw_stall_cnt_o(raw_stall_cnt_o), .miss_stall_cnt_o(miss_stall_cnt_o),
    .dbg_state_o(dbg_state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_miss;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id_in(input logic v, input logic [RW-1:0] rs1, input logic u1,
                       input logic [RW-1:0] rs2, input logic u2,
                       input logic [RW-1:0] rd, input logic we, input logic [SW-1:0] rdy);
    id_valid_i = v;  id_rs1_i = rs1; id_rs1_used_i = u1;
    id_rs2_i = rs2;  id_rs2_used_i = u2;
    id_rd_i = rd;    id_we_i = we;   id_rdy_stage_i = rdy;
  endtask

  task automatic drain();
    id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    repeat (NS) step();
    chk("drain_valid", 32'(stage_valid_o), 32'd0);
  endtask

  initial begin
    // reset: I-cache deliberately missing to show the controls stay quiet
    #2;
    chk("rst_flush", 32'(id_flush_o), 32'd1);
    chk("rst_pc_stall", 32'(pc_stall_o), 32'd0);
    chk("rst_id_stall", 32'(id_stall_o), 32'd0);
    chk("rst_issue", 32'(issue_o), 32'd0);
    chk("rst_freeze", 32'(freeze_o), 32'd0);
    chk("rst_valid", 32'(stage_valid_o), 32'd0);
    chk("rst_raw_cnt", 32'(raw_stall_cnt_o), 32'd0);
    chk("rst_miss_cnt", 32'(miss_stall_cnt_o), 32'd0);
    chk("rst_state", 32'(dbg_state_o), 32'(HS_RUN));
    icache_ready_i = 1'b1;
    step();
    step();
    reset_ni = 1'b1;

    // 1: ALU producer x5, consumers at distance 1 and 2
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd1);
    #1;
    chk("t1_prod_issue", 32'(issue_o), 32'd1);
    chk("t1_prod_pc", 32'(pc_stall_o), 32'd0);
    step();
    id_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 2'd1);
    #1;
    chk("t1_fwd_ex", 32'(fwd_rs1_o), 32'd1);
    chk("t1_fwd_rs2", 32'(fwd_rs2_o), 32'd0);
    chk("t1_issue_a", 32'(issue_o), 32'd1);
    step();
    id_in(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'd1);
    #1;
    chk("t1_fwd_mem", 32'(fwd_rs1_o), 32'd2);
    chk("t1_issue_b", 32'(issue_o), 32'd1);
    step();
    chk("t1_valid", 32'(stage_valid_o), 32'b111);
    drain();

    // 2: load x6 then immediate use on rs2
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd2);
    #1;
    chk("t2_load_issue", 32'(issue_o), 32'd1);
    step();
    id_in(1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 5'd12, 1'b1, 2'd1);
    #1;
    chk("t2_stall_issue", 32'(issue_o), 32'd0);
    chk("t2_stall_pc", 32'(pc_stall_o), 32'd1);
    chk("t2_stall_id", 32'(id_stall_o), 32'd1);
    chk("t2_stall_flush", 32'(id_flush_o), 32'd0);
    chk("t2_cnt_before", 32'(raw_stall_cnt_o), 32'd0);
    step();
    chk("t2_cnt_after", 32'(raw_stall_cnt_o), 32'd1);
    chk("t2_bubble", 32'(stage_valid_o), 32'b010);
    #1;
    chk("t2_fwd", 32'(fwd_rs2_o), 32'd2);
    chk("t2_issue", 32'(issue_o), 32'd1);
    chk("t2_pc", 32'(pc_stall_o), 32'd0);
    step();
    chk("t2_valid", 32'(stage_valid_o), 32'b101);
    drain();

    // 3: x7 at stages 3 and 1 (x0 load in between), consumer reads x7 and x0
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd1);
    step();
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 2'd2);
    step();
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd1);
    step();
    chk("t3_valid", 32'(stage_valid_o), 32'b111);
    id_in(1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 2'd1);
    #1;
    chk("t3_youngest", 32'(fwd_rs1_o), 32'd1);
    chk("t3_x0_fwd", 32'(fwd_rs2_o), 32'd0);
    chk("t3_issue", 32'(issue_o), 32'd1);
    chk("t3_pc", 32'(pc_stall_o), 32'd0);
    step();
    drain();

    // 4: redirect overrides a pending load-use stall
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd2);
    step();
    id_in(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd16, 1'b1, 2'd1);
    redirect_i = 1'b1;
    #1;
    chk("t4_issue", 32'(issue_o), 32'd0);
    chk("t4_flush", 32'(id_flush_o), 32'd1);
    chk("t4_pc", 32'(pc_stall_o), 32'd0);
    chk("t4_id_stall", 32'(id_stall_o), 32'd0);
    step();
    redirect_i = 1'b0;
    id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    chk("t4_squash", 32'(stage_valid_o), 32'd0);
    chk("t4_raw_cnt", 32'(raw_stall_cnt_o), 32'd1);

    // 5: four-cycle D-miss freeze, redirect raised during it waits
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1);
    step();
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 2'd1);
    step();
    chk("t5_fill", 32'(stage_valid_o), 32'b011);
    id_in(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd17, 1'b1, 2'd1);
    dmem_req_i = 1'b1;
    dcache_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) redirect_i = 1'b1;
      #1;
      chk("t5_freeze", 32'(freeze_o), 32'd1);
      chk("t5_issue", 32'(issue_o), 32'd0);
      chk("t5_pc", 32'(pc_stall_o), 32'd1);
      chk("t5_id_stall", 32'(id_stall_o), 32'd1);
      chk("t5_no_flush", 32'(id_flush_o), 32'd0);
      step();
      chk("t5_hold", 32'(stage_valid_o), 32'b011);
      chk("t5_state", 32'(dbg_state_o), 32'(HS_DMISS));
    end
    chk("t5_miss_cnt", 32'(miss_stall_cnt_o), 32'd4);
    dcache_ready_i = 1'b1;
    #1;
    chk("t5_unfreeze", 32'(freeze_o), 32'd0);
    chk("t5_redir_flush", 32'(id_flush_o), 32'd1);
    chk("t5_redir_issue", 32'(issue_o), 32'd0);
    chk("t5_redir_pc", 32'(pc_stall_o), 32'd0);
    step();
    dmem_req_i = 1'b0;
    redirect_i = 1'b0;
    id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    chk("t5_after_redir", 32'(stage_valid_o), 32'b100);
    chk("t5_state_run", 32'(dbg_state_o), 32'(HS_RUN));
    chk("t5_miss_cnt_hold", 32'(miss_stall_cnt_o), 32'd4);

    // 6: I-miss bubbles, back end drains, counter saturates at 15
    icache_ready_i = 1'b0;
    exp_miss = 4;
    for (int i = 0; i < 13; i++) begin
      #1;
      chk("t6_pc", 32'(pc_stall_o), 32'd1);
      chk("t6_id_stall", 32'(id_stall_o), 32'd1);
      chk("t6_flush", 32'(id_flush_o), 32'd1);
      chk("t6_issue", 32'(issue_o), 32'd0);
      step();
      exp_miss = (exp_miss == 15) ? 15 : exp_miss + 1;
      chk("t6_miss_cnt", 32'(miss_stall_cnt_o), 32'(exp_miss));
      if (i == 0) chk("t6_shift", 32'(stage_valid_o), 32'd0);
    end
    chk("t6_saturated", 32'(miss_stall_cnt_o), 32'd15);
    icache_ready_i = 1'b1;

    // async reset in the middle of a D-miss
    id_in(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 1'b1, 2'd1);
    step();
    id_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0);
    dmem_req_i = 1'b1;
    dcache_ready_i = 1'b0;
    step();
    step();
    chk("rm_state_pre", 32'(dbg_state_o), 32'(HS_DMISS));
    chk("rm_valid_pre", 32'(stage_valid_o), 32'b001);
    chk("rm_freeze_pre", 32'(freeze_o), 32'd1);
    reset_ni = 1'b0;
    #1;
    chk("rm_state", 32'(dbg_state_o), 32'(HS_RUN));
    chk("rm_valid", 32'(stage_valid_o), 32'd0);
    chk("rm_freeze", 32'(freeze_o), 32'd0);
    chk("rm_miss_cnt", 32'(miss_stall_cnt_o), 32'd0);
    chk("rm_raw_cnt", 32'(raw_stall_cnt_o), 32'd0);
    chk("rm_flush", 32'(id_flush_o), 32'd1);
    chk("rm_pc", 32'(pc_stall_o), 32'd0);
    dmem_req_i = 1'b0;
    dcache_ready_i = 1'b1;
    step();
    reset_ni = 1'b1;
    #1;
    chk("rm_idle_freeze", 32'(freeze_o), 32'd0);
    chk("rm_idle_flush", 32'(id_flush_o), 32'd0);
    chk("rm_idle_pc", 32'(pc_stall_o), 32'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
